elevador_posicion: RTL

Shaft-side position model for the elevator. It takes the motor commands issued by the elevator controller (`motor_subir`, `motor_bajar`) and integrates them into a car position. From that position it derives the current floor, a floor-level flag, a one-cycle arrival pulse and a 7-segment floor display. It also latches a fault on illegal commands. It sits between the controller's motor outputs and the controller's floor/display inputs, closing the loop in the top-level design.

---
 rtl/elevador_pkg.sv | 24 ++
 rtl/elevador_7seg.sv | 37 +++
 rtl/elevador_posicion.sv | 109 ++++++++++
 3 files changed

// File: rtl/elevador_pkg.sv
// Shared elevator types: car state enum and seven-segment constants.
// No logic; used by the position model, the decoder and the controller.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package elevador_pkg;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    SUBIENDO = 2'd1,
    BAJANDO  = 2'd2,
    FALLA    = 2'd3
  } estado_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_GUION = 7'h40;
  localparam logic [6:0] SEG_F     = 7'h71;

endpackage

// File: rtl/elevador_7seg.sv
// Floor digit to seven-segment decoder with a fault override ("F").
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module elevador_7seg
  import elevador_pkg::*;
#(
  parameter int PISO_W = 2
) (
  input  logic [PISO_W-1:0] digito,
  input  logic              falla,
  output logic [6:0]        seg
);

  logic [31:0] valor;

  // Fault wins over the floor digit; floors beyond 7 show a dash.
  always_comb begin
    valor = 32'(digito);
    seg   = SEG_GUION;
    if (falla) begin
      seg = SEG_F;
    end else begin
      case (valor)
        32'd0:   seg = SEG_0;
        32'd1:   seg = SEG_1;
        32'd2:   seg = SEG_2;
        32'd3:   seg = SEG_3;
        32'd4:   seg = SEG_4;
        32'd5:   seg = SEG_5;
        32'd6:   seg = SEG_6;
        32'd7:   seg = SEG_7;
        default: seg = SEG_GUION;
      endcase
    end
  end

endmodule

// File: rtl/elevador_posicion.sv
// Car position model: integrates motor commands into pos, floor, arrival pulse, display.
// Latency: command to pos/piso 1 cycle; display lags piso by one more cycle.
// Backpressure: none; commands sampled every cycle, illegal ones latch a sticky fault.
// Optional: define ELEVADOR_DISPLAY_EN to build the seven-segment output, else display=0.
module elevador_posicion
  import elevador_pkg::*;
#(
  parameter int NUM_PISOS      = 4,
  parameter int TICKS_POR_PISO = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         motor_subir,
  input  logic                         motor_bajar,
  output logic [$clog2(NUM_PISOS)-1:0] piso,
  output logic                         en_piso,
  output logic                         llegada,
  output logic                         moviendo,
  output logic                         falla,
  output logic [7:0]                   display
);

  localparam int PISO_W = $clog2(NUM_PISOS);
  localparam int LOG2T  = $clog2(TICKS_POR_PISO);
  // pos splits as {floor, ticks within floor}, so floor decode is a plain slice.
  localparam int POS_W  = PISO_W + LOG2T;
  localparam logic [POS_W-1:0] POS_MAX = POS_W'((NUM_PISOS - 1) * TICKS_POR_PISO);

  estado_e          estado_q, estado_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             llegada_q, llegada_d;

  // State, position and arrival registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q  <= PARADO;
      pos_q     <= '0;
      llegada_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      pos_q     <= pos_d;
      llegada_q <= llegada_d;
    end
  end

  // Next state and position; FALLA freezes everything until reset.
  always_comb begin
    estado_d  = estado_q;
    pos_d     = pos_q;
    llegada_d = 1'b0;
    if (estado_q != FALLA) begin
      case ({motor_subir, motor_bajar})
        2'b11: estado_d = FALLA;
        2'b10: begin
          if (pos_q == POS_MAX) begin
            estado_d = FALLA;
          end else begin
            pos_d    = pos_q + POS_W'(1);
            estado_d = SUBIENDO;
          end
        end
        2'b01: begin
          if (pos_q == '0) begin
            estado_d = FALLA;
          end else begin
            pos_d    = pos_q - POS_W'(1);
            estado_d = BAJANDO;
          end
        end
        default: estado_d = PARADO;
      endcase
      // Arrival only counts when the car actually moved onto a floor.
      llegada_d = (pos_d != pos_q) && (pos_d[LOG2T-1:0] == '0);
    end
  end

  assign piso     = pos_q[POS_W-1:LOG2T];
  assign en_piso  = (pos_q[LOG2T-1:0] == '0);
  assign llegada  = llegada_q;
  assign moviendo = (estado_q == SUBIENDO) || (estado_q == BAJANDO);
  assign falla    = (estado_q == FALLA);

`ifdef ELEVADOR_DISPLAY_EN
  logic [6:0] seg;
  logic [7:0] display_q;

  elevador_7seg #(
    .PISO_W (PISO_W)
  ) u_7seg (
    .digito (piso),
    .falla  (falla),
    .seg    (seg)
  );

  // Registered display; shows floor 0 while held in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display_q <= {1'b0, SEG_0};
    end else begin
      display_q <= {moviendo, seg};
    end
  end

  assign display = display_q;
`else
  assign display = 8'h00;
`endif

endmodule
